// File: rtl/axi_mem_pkg.sv
// Shared widths, AXI response codes, FSM state types and the latched request
// payload for the AXI memory responder.
package axi_mem_pkg;

    localparam int unsigned ADDR_W = 64;
    localparam int unsigned DATA_W = 128;
    localparam int unsigned STRB_W = 16;
    localparam int unsigned ID_W   = 4;
    localparam int unsigned LEN_W  = 8;
    localparam int unsigned SIZE_W = 3;
    localparam int unsigned RESP_W = 2;

    localparam logic [RESP_W-1:0] RESP_OKAY   = 2'b00;
    localparam logic [RESP_W-1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } w_state_e;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_ADDR = 2'd1,
        R_DATA = 2'd2
    } r_state_e;

    // Latched AW/AR request; addr advances in place as beats are served
    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [ADDR_W-1:0] addr;
        logic [LEN_W-1:0]  len;
        logic [SIZE_W-1:0] size;
    } ax_req_t;

    function automatic logic [ADDR_W-1:0] beat_step(input logic [SIZE_W-1:0] size);
        return ADDR_W'(1) << size;
    endfunction

endpackage

// File: rtl/axi_mem_ram.sv
// Simple dual-port RAM: byte-enabled write port, registered read port,
// read-first on a same-cycle collision.
module axi_mem_ram
    import axi_mem_pkg::*;
#(
    parameter int unsigned LOG2_DEPTH = 9
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [LOG2_DEPTH-1:0] wr_idx,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic [STRB_W-1:0]     wr_strb,
    input  logic                  rd_en,
    input  logic                  rd_clr,
    input  logic [LOG2_DEPTH-1:0] rd_idx,
    output logic [DATA_W-1:0]     rd_data
);

    localparam int unsigned DEPTH = 1 << LOG2_DEPTH;

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < int'(STRB_W); b++) begin
                if (wr_strb[b]) begin
                    mem[wr_idx][b*8 +: 8] <= wr_data[b*8 +: 8];
                end
            end
        end
    end

    // rd_clr forces zero data for beats that fall outside the memory
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_idx];
        end else if (rd_clr) begin
            rd_data <= '0;
        end
    end

endmodule

// File: rtl/axi_mem_responder.sv
// AXI4 slave backed by on-chip 128-bit word memory; independent single-burst
// write and read engines, all bursts treated as INCR.
module axi_mem_responder
    import axi_mem_pkg::*;
#(
    parameter int unsigned       LOG2_DEPTH = 9,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = 64'h0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [ADDR_W-1:0]    s_awaddr,
    input  logic [ID_W-1:0]      s_awid,
    input  logic [LEN_W-1:0]     s_awlen,
    input  logic [SIZE_W-1:0]    s_awsize,
    input  logic [1:0]           s_awburst,
    input  logic                 s_awvalid,
    output logic                 s_awready,
    input  logic [DATA_W-1:0]    s_wdata,
    input  logic [STRB_W-1:0]    s_wstrb,
    input  logic                 s_wlast,
    input  logic                 s_wvalid,
    output logic                 s_wready,
    output logic [ID_W-1:0]      s_bid,
    output logic [RESP_W-1:0]    s_bresp,
    output logic                 s_bvalid,
    input  logic                 s_bready,
    input  logic [ADDR_W-1:0]    s_araddr,
    input  logic [ID_W-1:0]      s_arid,
    input  logic [LEN_W-1:0]     s_arlen,
    input  logic [SIZE_W-1:0]    s_arsize,
    input  logic [1:0]           s_arburst,
    input  logic                 s_arvalid,
    output logic                 s_arready,
    output logic [DATA_W-1:0]    s_rdata,
    output logic [ID_W-1:0]      s_rid,
    output logic [RESP_W-1:0]    s_rresp,
    output logic                 s_rlast,
    output logic                 s_rvalid,
    input  logic                 s_rready
);

    // Burst type is deliberately ignored
    logic unused_burst;
    assign unused_burst = ^{s_awburst, s_arburst};

    function automatic logic addr_in_range(input logic [ADDR_W-1:0] a);
        logic [ADDR_W-1:0] off;
        off = a - BASE_ADDR;
        return (a >= BASE_ADDR) && ((off >> (LOG2_DEPTH + 4)) == '0);
    endfunction

    function automatic logic [LOG2_DEPTH-1:0] word_idx(input logic [ADDR_W-1:0] a);
        return LOG2_DEPTH'((a - BASE_ADDR) >> 4);
    endfunction

    // ---------------- write engine ----------------
    w_state_e              w_state, w_next;
    ax_req_t               aw_q, aw_d;
    logic [LEN_W-1:0]      w_cnt_q, w_cnt_d;
    logic                  w_err_q, w_err_d;
    logic                  w_hit, w_last, mem_we;
    logic [LOG2_DEPTH-1:0] w_idx;
    logic                  aw_ready_d, w_ready_d, b_valid_d;
    logic [ID_W-1:0]       b_id_d;
    logic [RESP_W-1:0]     b_resp_d;

    always_comb begin
        w_next   = w_state;
        aw_d     = aw_q;
        w_cnt_d  = w_cnt_q;
        w_err_d  = w_err_q;
        mem_we   = 1'b0;
        b_id_d   = s_bid;
        b_resp_d = s_bresp;
        w_hit    = addr_in_range(aw_q.addr);
        w_idx    = word_idx(aw_q.addr);
        w_last   = (w_cnt_q == aw_q.len);

        case (w_state)
            W_IDLE: begin
                if (s_awvalid && s_awready) begin
                    aw_d    = '{id: s_awid, addr: s_awaddr, len: s_awlen, size: s_awsize};
                    w_cnt_d = '0;
                    w_err_d = 1'b0;
                    w_next  = W_DATA;
                end
            end
            W_DATA: begin
                if (s_wvalid && s_wready) begin
                    mem_we    = w_hit;
                    w_err_d   = w_err_q | ~w_hit | (s_wlast != w_last);
                    w_cnt_d   = w_cnt_q + LEN_W'(1);
                    aw_d.addr = aw_q.addr + beat_step(aw_q.size);
                    // Burst ends on the beat count, not on wlast
                    if (w_last) begin
                        w_next   = W_RESP;
                        b_id_d   = aw_q.id;
                        b_resp_d = w_err_d ? RESP_SLVERR : RESP_OKAY;
                    end
                end
            end
            W_RESP: begin
                if (s_bvalid && s_bready) begin
                    w_next = W_IDLE;
                end
            end
            default: w_next = W_IDLE;
        endcase

        aw_ready_d = (w_next == W_IDLE);
        w_ready_d  = (w_next == W_DATA);
        b_valid_d  = (w_next == W_RESP);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_state   <= W_IDLE;
            aw_q      <= '0;
            w_cnt_q   <= '0;
            w_err_q   <= 1'b0;
            s_awready <= 1'b0;
            s_wready  <= 1'b0;
            s_bvalid  <= 1'b0;
            s_bid     <= '0;
            s_bresp   <= RESP_OKAY;
        end else begin
            w_state   <= w_next;
            aw_q      <= aw_d;
            w_cnt_q   <= w_cnt_d;
            w_err_q   <= w_err_d;
            s_awready <= aw_ready_d;
            s_wready  <= w_ready_d;
            s_bvalid  <= b_valid_d;
            s_bid     <= b_id_d;
            s_bresp   <= b_resp_d;
        end
    end

    // ---------------- read engine ----------------
    r_state_e              r_state, r_next;
    ax_req_t               ar_q, ar_d;
    logic [LEN_W-1:0]      r_cnt_q, r_cnt_d;
    logic                  r_hit, rd_en, rd_clr;
    logic [LOG2_DEPTH-1:0] r_idx;
    logic                  ar_ready_d, r_valid_d, r_last_d;
    logic [ID_W-1:0]       r_id_d;
    logic [RESP_W-1:0]     r_resp_d;

    always_comb begin
        r_next   = r_state;
        ar_d     = ar_q;
        r_cnt_d  = r_cnt_q;
        rd_en    = 1'b0;
        rd_clr   = 1'b0;
        r_id_d   = s_rid;
        r_resp_d = s_rresp;
        r_last_d = s_rlast;
        r_hit    = addr_in_range(ar_q.addr);
        r_idx    = word_idx(ar_q.addr);

        case (r_state)
            R_IDLE: begin
                if (s_arvalid && s_arready) begin
                    ar_d    = '{id: s_arid, addr: s_araddr, len: s_arlen, size: s_arsize};
                    r_cnt_d = '0;
                    r_next  = R_ADDR;
                end
            end
            R_ADDR: begin
                rd_en    = r_hit;
                rd_clr   = ~r_hit;
                r_id_d   = ar_q.id;
                r_resp_d = r_hit ? RESP_OKAY : RESP_SLVERR;
                r_last_d = (r_cnt_q == ar_q.len);
                r_next   = R_DATA;
            end
            R_DATA: begin
                if (s_rvalid && s_rready) begin
                    if (s_rlast) begin
                        r_next = R_IDLE;
                    end else begin
                        r_cnt_d   = r_cnt_q + LEN_W'(1);
                        ar_d.addr = ar_q.addr + beat_step(ar_q.size);
                        r_next    = R_ADDR;
                    end
                end
            end
            default: r_next = R_IDLE;
        endcase

        ar_ready_d = (r_next == R_IDLE);
        r_valid_d  = (r_next == R_DATA);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= R_IDLE;
            ar_q      <= '0;
            r_cnt_q   <= '0;
            s_arready <= 1'b0;
            s_rvalid  <= 1'b0;
            s_rid     <= '0;
            s_rresp   <= RESP_OKAY;
            s_rlast   <= 1'b0;
        end else begin
            r_state   <= r_next;
            ar_q      <= ar_d;
            r_cnt_q   <= r_cnt_d;
            s_arready <= ar_ready_d;
            s_rvalid  <= r_valid_d;
            s_rid     <= r_id_d;
            s_rresp   <= r_resp_d;
            s_rlast   <= r_last_d;
        end
    end

    axi_mem_ram #(
        .LOG2_DEPTH (LOG2_DEPTH)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (mem_we),
        .wr_idx  (w_idx),
        .wr_data (s_wdata),
        .wr_strb (s_wstrb),
        .rd_en   (rd_en),
        .rd_clr  (rd_clr),
        .rd_idx  (r_idx),
        .rd_data (s_rdata)
    );

endmodule
